// File: rtl/harmonic_scheduler_pkg.sv
// Shared definitions for the harmonic scheduler slice.
// Contents: FSM state enum, default divider and harmonic-count constants,
// and the offset-binary midscale code used for silence and reset.
package sched_pkg;

    localparam int          DEFAULT_CLK_DIV   = 1000;
    localparam int          DEFAULT_HARMONICS = 64;
    localparam logic [15:0] MIDSCALE          = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } sched_state_e;

endpackage

// File: rtl/harmonic_scheduler_if.sv
// Bus bundle between the harmonic scheduler and its surroundings.
// Groups control input (enable, harmonic count), the datapath issue/return
// handshake, the DAC sample handshake and the status outputs.
//   master : the scheduler side (drives o_* signals)
//   slave  : the environment side (drives i_* signals)
// Optional: SCHED_OVERRUN_COUNT_EN adds the saturating o_Overrun_Count[7:0].
interface harmonic_scheduler_if
    import sched_pkg::*;
#(
    parameter int HARMONICS = DEFAULT_HARMONICS,
    parameter int PROD_W    = 28
);
    localparam int HW = $clog2(HARMONICS);

    logic              i_Enable;
    logic [HW:0]       i_Harm_Count;
    logic [HW-1:0]     o_Harm_Index;
    logic              o_Harm_Valid;
    logic              i_Harm_Ready;
    logic              i_Prod_Valid;
    logic [PROD_W-1:0] i_Product;
    logic [15:0]       o_Sample;
    logic              o_Sample_Valid;
    logic              i_DAC_Ready;
    logic              o_Busy;
    logic              o_Overrun;
`ifdef SCHED_OVERRUN_COUNT_EN
    logic [7:0]        o_Overrun_Count;
`endif

    modport master (
        input  i_Enable,
        input  i_Harm_Count,
        output o_Harm_Index,
        output o_Harm_Valid,
        input  i_Harm_Ready,
        input  i_Prod_Valid,
        input  i_Product,
        output o_Sample,
        output o_Sample_Valid,
        input  i_DAC_Ready,
        output o_Busy,
        output o_Overrun
`ifdef SCHED_OVERRUN_COUNT_EN
        ,
        output o_Overrun_Count
`endif
    );

    modport slave (
        output i_Enable,
        output i_Harm_Count,
        input  o_Harm_Index,
        input  o_Harm_Valid,
        output i_Harm_Ready,
        output i_Prod_Valid,
        output i_Product,
        input  o_Sample,
        input  o_Sample_Valid,
        output i_DAC_Ready,
        input  o_Busy,
        input  o_Overrun
`ifdef SCHED_OVERRUN_COUNT_EN
        ,
        input  o_Overrun_Count
`endif
    );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider.
// Ports: i_Clock, i_Reset (async, active high), o_Tick (one-cycle pulse
// while the counter sits at its terminal count CLK_DIV-1).
module sample_tick_gen #(
    parameter int CLK_DIV = 1000
)(
    input  logic i_Clock,
    input  logic i_Reset,
    output logic o_Tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter 0..CLK_DIV-1; tick registered one count early so it lines up with terminal count.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CW'(CLK_DIV - 1)) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick_r <= (cnt_r == CW'(CLK_DIV - 2));
        end
    end

    assign o_Tick = tick_r;

endmodule

// File: rtl/harmonic_scheduler.sv
// Per-sample sequencer for the additive oscillator.
// Each accepted sample tick: issue harmonic indices 0..n-1 to the shared
// sine/multiply datapath, accumulate the returned signed products, scale by
// OUT_SHIFT, saturate to 16 bits and offer an offset-binary sample to the DAC.
// Ports: i_Clock, i_Reset (async, active high), bus (harmonic_scheduler_if.master).
// Optional: SCHED_OVERRUN_COUNT_EN adds a saturating 8-bit overrun counter.
module harmonic_scheduler
    import sched_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int HARMONICS = DEFAULT_HARMONICS,
    parameter int PROD_W    = 28,
    parameter int OUT_SHIFT = 12
)(
    input logic                    i_Clock,
    input logic                    i_Reset,
    harmonic_scheduler_if.master   bus
);
    localparam int HW    = $clog2(HARMONICS);
    localparam int CW    = HW + 1;
    localparam int ACC_W = PROD_W + HW;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ISSUE  = ST_ISSUE;
    localparam logic [1:0] S_DRAIN  = ST_DRAIN;
    localparam logic [1:0] S_OUTPUT = ST_OUTPUT;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    logic [1:0]              state_r;
    logic [CW-1:0]           n_r;
    logic [CW-1:0]           issue_cnt_r;
    logic [CW-1:0]           ret_cnt_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    harm_valid_r;
    logic [HW-1:0]           harm_index_r;
    logic [15:0]             sample_r;
    logic                    sample_valid_r;
    logic                    busy_r;
    logic                    overrun_r;

    logic                    tick_s;
    logic                    tick_accept_s;
    logic                    overrun_set_s;
    logic                    issue_hs_s;
    logic                    ret_s;
    logic [CW-1:0]           n_in_s;
    logic [CW-1:0]           ret_next_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic [15:0]             sat_s;
    logic [15:0]             sample_s;

    sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .o_Tick  (tick_s)
    );

    assign tick_accept_s = tick_s && bus.i_Enable;
    assign overrun_set_s = tick_accept_s && (state_r != S_IDLE);
    assign issue_hs_s    = harm_valid_r && bus.i_Harm_Ready;
    // Returns only count while a sequence is collecting; stragglers in IDLE/OUTPUT are dropped.
    assign ret_s         = bus.i_Prod_Valid && ((state_r == S_ISSUE) || (state_r == S_DRAIN));
    assign n_in_s        = (bus.i_Harm_Count > CW'(HARMONICS)) ? CW'(HARMONICS) : bus.i_Harm_Count;
    assign ret_next_s    = ret_cnt_r + (ret_s ? CW'(1) : CW'(0));
    assign prod_ext_s    = {{(ACC_W - PROD_W){bus.i_Product[PROD_W-1]}}, bus.i_Product};
    assign acc_next_s    = ret_s ? (acc_r + prod_ext_s) : acc_r;
    assign shifted_s     = acc_next_s >>> OUT_SHIFT;

    // Clamp the scaled sum to the signed 16-bit range.
    always_comb begin
        sat_s = 16'h0000;
        if (shifted_s > SAT_MAX) begin
            sat_s = 16'h7FFF;
        end else if (shifted_s < SAT_MIN) begin
            sat_s = 16'h8000;
        end else begin
            sat_s = shifted_s[15:0];
        end
    end

    // Two's complement to offset binary: flip the sign bit.
    assign sample_s = {~sat_s[15], sat_s[14:0]};

    // Sequencer FSM: tick acceptance, issue/return counting, accumulation and DAC handshake.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_r        <= S_IDLE;
            n_r            <= {CW{1'b0}};
            issue_cnt_r    <= {CW{1'b0}};
            ret_cnt_r      <= {CW{1'b0}};
            acc_r          <= {ACC_W{1'b0}};
            harm_valid_r   <= 1'b0;
            harm_index_r   <= {HW{1'b0}};
            sample_r       <= MIDSCALE;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            overrun_r <= overrun_set_s;
            case (state_r)
                S_IDLE: begin
                    if (tick_accept_s) begin
                        n_r          <= n_in_s;
                        issue_cnt_r  <= {CW{1'b0}};
                        ret_cnt_r    <= {CW{1'b0}};
                        acc_r        <= {ACC_W{1'b0}};
                        harm_index_r <= {HW{1'b0}};
                        busy_r       <= 1'b1;
                        if (n_in_s == {CW{1'b0}}) begin
                            state_r        <= S_OUTPUT;
                            sample_r       <= MIDSCALE;
                            sample_valid_r <= 1'b1;
                        end else begin
                            state_r      <= S_ISSUE;
                            harm_valid_r <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    acc_r     <= acc_next_s;
                    ret_cnt_r <= ret_next_s;
                    if (issue_hs_s) begin
                        issue_cnt_r <= issue_cnt_r + CW'(1);
                        if ((issue_cnt_r + CW'(1)) == n_r) begin
                            harm_valid_r <= 1'b0;
                            state_r      <= S_DRAIN;
                        end else begin
                            harm_index_r <= harm_index_r + HW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    acc_r     <= acc_next_s;
                    ret_cnt_r <= ret_next_s;
                    // Includes a final return arriving this very cycle.
                    if (ret_next_s >= n_r) begin
                        state_r        <= S_OUTPUT;
                        sample_r       <= sample_s;
                        sample_valid_r <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (bus.i_DAC_Ready) begin
                        sample_valid_r <= 1'b0;
                        busy_r         <= 1'b0;
                        state_r        <= S_IDLE;
                    end
                end
                default: begin
                    state_r        <= S_IDLE;
                    harm_valid_r   <= 1'b0;
                    sample_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCHED_OVERRUN_COUNT_EN
    logic [7:0] ovr_cnt_r;

    // Saturating count of dropped ticks; only reset clears it.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            ovr_cnt_r <= 8'd0;
        end else if (overrun_set_s && (ovr_cnt_r != 8'hFF)) begin
            ovr_cnt_r <= ovr_cnt_r + 8'd1;
        end else begin
            ovr_cnt_r <= ovr_cnt_r;
        end
    end

    assign bus.o_Overrun_Count = ovr_cnt_r;
`endif

    assign bus.o_Harm_Index   = harm_index_r;
    assign bus.o_Harm_Valid   = harm_valid_r;
    assign bus.o_Sample       = sample_r;
    assign bus.o_Sample_Valid = sample_valid_r;
    assign bus.o_Busy         = busy_r;
    assign bus.o_Overrun      = overrun_r;

endmodule

// File: doc/harmonic_scheduler.md
Name: harmonic_scheduler

Overview:
- Per-sample sequencer for the additive oscillator datapath.
- Every sample period it issues the active harmonic indices to the shared sine-lookup/multiply pipeline, accumulates the returned products, and scales/saturates the sum.
- It then hands one 16-bit offset-binary sample to the DAC SPI transmitter.
- Sits between the ADC-derived control registers and the DAC output, in the 48 MHz domain.

Parameters:
- CLK_DIV, 1000: i_Clock cycles per sample tick (48 MHz / 1000 = 48 kHz).
- HARMONICS, 64: maximum harmonic count; index width HW = clog2(HARMONICS).
- PROD_W, 28: signed product width returned by the datapath (12x16 multiply).
- ACC_W, PROD_W+clog2(HARMONICS): accumulator width.
- OUT_SHIFT, 12: arithmetic right shift applied to the accumulator before saturation.

Ports:
- i_Clock  in  1  48 MHz system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Enable  in  1  gates sample ticks; the divider free-runs regardless.
- i_Harm_Count  in  HW+1  number of active harmonics; latched at tick; 0 means output silence.
- o_Harm_Index  out  HW  harmonic index being issued.
- o_Harm_Valid  out  1  issue request to the datapath.
- i_Harm_Ready  in  1  datapath accepts an issue.
- i_Prod_Valid  in  1  product return strobe.
- i_Product  in  PROD_W  signed product.
- o_Sample  out  16  offset-binary sample to the DAC.
- o_Sample_Valid  out  1  sample offered.
- i_DAC_Ready  in  1  DAC transmitter idle; accepts the sample.
- o_Busy  out  1  high in any state other than IDLE.
- o_Overrun  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset values: all outputs 0, except o_Sample = 16'h8000 (midscale). FSM in IDLE, divider 0, accumulator 0.
- Divider: counts 0..CLK_DIV-1. The tick is asserted for one cycle at terminal count. A tick with i_Enable low is ignored and does not count as an overrun.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - On a tick with i_Enable high: latch n = min(i_Harm_Count, HARMONICS), clear the accumulator, issue and return counters to 0.
  - If n = 0, go to OUTPUT with a zero sum; otherwise go to ISSUE.
- ISSUE:
  - o_Harm_Valid = 1, o_Harm_Index = issue counter.
  - On Valid && Ready, increment the counter.
  - After the n-th handshake, go to DRAIN on the next cycle.
  - o_Harm_Index is held stable while Valid is high and Ready is low.
- Product return (ISSUE and DRAIN):
  - On each i_Prod_Valid: acc += sign-extended i_Product, and the return counter increments.
  - A return in the same cycle as an issue is legal; both counters update.
  - i_Prod_Valid in IDLE or OUTPUT is ignored.
- DRAIN: when the return counter reaches n (including a final return this cycle), go to OUTPUT.
- OUTPUT scaling:
  - s = acc >>> OUT_SHIFT, saturated to the range -32768..32767.
  - o_Sample = {~s[15], s[14:0]}.
  - The sample is registered on entry, and o_Sample_Valid rises one cycle after the final return.
- OUTPUT handshake: hold o_Sample_Valid until i_DAC_Ready; on Valid && Ready, return to IDLE. o_Sample keeps its last value after the handshake.
- Overrun: a tick (with i_Enable high) arriving in any state other than IDLE is dropped. o_Overrun pulses for one cycle and the current sequence continues unaffected.
- Latency: first issue one cycle after the tick. With zero-stall Ready, n issues take n cycles.
- i_Enable deasserted mid-sequence: the current sample completes; no new ticks are accepted.
- i_Reset asserted mid-sequence: immediate return to IDLE with reset values. Products still in flight in the datapath after reset are ignored, because the FSM is in IDLE.

Optional Feature:
- SCHED_OVERRUN_COUNT_EN defined:
  - Adds output o_Overrun_Count[7:0], which increments on each o_Overrun pulse and saturates at 255.
  - Cleared only by i_Reset.
- Not defined: the port is absent and only the o_Overrun pulse exists.

Decomposition:
- Shared package sched_pkg holds:
  - FSM state enum (IDLE, ISSUE, DRAIN, OUTPUT).
  - Default CLK_DIV and HARMONICS constants.
  - The offset-binary midscale constant 16'h8000.
- One natural sub-module, sample_tick_gen: the CLK_DIV divider producing a one-cycle tick.
- Saturation stays inline.

Test Plan:
- Reset, then i_Enable = 1 with i_Harm_Count = 0 and i_DAC_Ready = 1 -> at each tick (every 1000 cycles) o_Sample = 16'h8000 and o_Sample_Valid pulses for one cycle; no o_Harm_Valid.
- i_Harm_Count = 3, Ready always 1, products returned with 2-cycle latency, each = 4096 (2^12) -> indices 0, 1, 2 issued on consecutive cycles; accumulator 12288 -> o_Sample = 16'h8003.
- i_Harm_Count = 64, each product = +(2^27 - 1) -> saturates to o_Sample = 16'hFFFF; the same test with -(2^27) gives 16'h0000.
- Ready toggling 1-0-0-1 during ISSUE -> o_Harm_Index stable while stalled; exactly n issues; sum unchanged versus the no-stall run.
- i_DAC_Ready held low for 1200 cycles -> o_Overrun pulses once at the next tick; o_Sample_Valid stays high; with SCHED_OVERRUN_COUNT_EN, count = 1. The sample releases when Ready rises.
- Assert i_Reset during DRAIN with 2 products outstanding -> outputs return to reset values; late i_Prod_Valid is ignored; the next tick produces the correct fresh sum.
